// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous level into the CLK domain.
// Emits a filtered level plus one-cycle rise/fall pulses on each accepted change.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Qualification: s_sync must disagree with dout on STABLE_CYCLES+1
    // consecutive edges; any agreeing edge drops back to STABLE.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                ST_STABLE: begin
                    cnt_q <= '0;
                    if (s_sync != dout_q) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s_sync == dout_q) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                        dout_q  <= ~dout_q;
                        rise_q  <= ~dout_q;
                        fall_q  <= dout_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_WAIT);

endmodule
